lz77_token_sched: RTL

LZ77_TOKEN_SCHED -- requirements
Module: lz77_token_sched

---
 rtl/lz77_token_sched_if.sv | 30 +++
 rtl/lz77_token_sched.sv | 116 +++++++++++
 2 files changed

// File: rtl/lz77_token_sched_if.sv
// lz77_token_sched_if: token-in / symbol-out handshake bundle for lz77_token_sched
//   tok_valid/tok_ready  token handshake (upstream -> scheduler)
//   tok_pos[3:0]         copy position, legal 0..6
//   tok_len[2:0]         copy length 0..7
//   tok_char[7:0]        terminating literal
//   dec_valid/dec_ready  symbol handshake (scheduler -> decoder)
//   dec_lit              1 = literal dec_char, 0 = copy from dec_pos
//   dec_pos[3:0]         copy position
//   dec_char[7:0]        literal
//   modport master: token source / decoder sink; modport slave: the scheduler
interface lz77_token_sched_if;
    logic       tok_valid;
    logic       tok_ready;
    logic [3:0] tok_pos;
    logic [2:0] tok_len;
    logic [7:0] tok_char;
    logic       dec_valid;
    logic       dec_ready;
    logic       dec_lit;
    logic [3:0] dec_pos;
    logic [7:0] dec_char;
    modport master (
        output tok_valid, tok_pos, tok_len, tok_char, dec_ready,
        input  tok_ready, dec_valid, dec_lit, dec_pos, dec_char
    );
    modport slave (
        input  tok_valid, tok_pos, tok_len, tok_char, dec_ready,
        output tok_ready, dec_valid, dec_lit, dec_pos, dec_char
    );
endinterface

// File: rtl/lz77_token_sched.sv
// lz77_token_sched: expands LZ77 tokens into tok_len copy symbols plus one literal
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   bus     lz77_token_sched_if.slave (token in, decoder symbol out)
//   finish  sticky, terminator literal 8'h24 emitted
//   err     sticky, a token with tok_pos > 6 was accepted
// Optional macro LZ77_SCHED_PREFETCH_EN adds a 2-entry token FIFO so tokens
// stream back-to-back; without it one token is held and a bubble separates tokens.
module lz77_token_sched (
    input  logic              clk,
    input  logic              reset,
    lz77_token_sched_if.slave bus,
    output logic              finish,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;
    state_t      state, state_n;
    logic        alive, accept, fire, load, last, nxt_valid;
    logic        valid_n, lit_n, fin_n;
    logic [2:0]  cnt, cnt_n, len, len_n;
    logic [3:0]  pos_n;
    logic [7:0]  char_n;
    logic [14:0] in_tok, nxt_tok;

    // tokens are stored as {clamped pos, len, char}
    assign in_tok = {(bus.tok_pos > 4'd6 ? 4'd6 : bus.tok_pos), bus.tok_len, bus.tok_char};
    assign accept = bus.tok_valid && bus.tok_ready;
    assign fire   = bus.dec_valid && bus.dec_ready;
    assign last   = cnt == len - 3'd1;
    assign load   = nxt_valid && (state == IDLE || (state == LIT && fire && bus.dec_char != 8'h24));

`ifdef LZ77_SCHED_PREFETCH_EN
    logic [1:0]  occ;
    logic [14:0] head, tail;
    logic        push, pop;
    // an empty FIFO is bypassed so a token accepted from IDLE still shows next cycle
    assign bus.tok_ready = alive && state != DONE && occ != 2'd2;
    assign nxt_valid     = occ != 2'd0 || accept;
    assign nxt_tok       = occ != 2'd0 ? head : in_tok;
    assign pop           = load && occ != 2'd0;
    assign push          = accept && !(load && occ == 2'd0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            if (pop) head <= tail;
            if (push && (pop || occ == 2'd0)) head <= in_tok;
            else if (push) tail <= in_tok;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
`else
    assign bus.tok_ready = alive && state == IDLE;
    assign nxt_valid     = accept;
    assign nxt_tok       = in_tok;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        valid_n = bus.dec_valid;
        lit_n   = bus.dec_lit;
        pos_n   = bus.dec_pos;
        char_n  = bus.dec_char;
        fin_n   = finish;
        if (load) begin
            state_n = nxt_tok[10:8] == 3'd0 ? LIT : COPY;
            valid_n = 1'b1;
            lit_n   = nxt_tok[10:8] == 3'd0;
            pos_n   = nxt_tok[14:11];
            char_n  = nxt_tok[7:0];
            cnt_n   = 3'd0;
            len_n   = nxt_tok[10:8];
        end else if (fire && state == COPY) begin
            state_n = last ? LIT : COPY;
            lit_n   = last;
            cnt_n   = last ? cnt : cnt + 3'd1;
        end else if (fire && state == LIT) begin
            valid_n = 1'b0;
            state_n = bus.dec_char == 8'h24 ? DONE : IDLE;
            fin_n   = bus.dec_char == 8'h24;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive        <= 1'b0;
            cnt          <= 3'd0;
            len          <= 3'd0;
            bus.dec_valid <= 1'b0;
            bus.dec_lit  <= 1'b0;
            bus.dec_pos  <= 4'd0;
            bus.dec_char <= 8'h00;
            finish       <= 1'b0;
            err          <= 1'b0;
        end else begin
            alive        <= 1'b1;
            cnt          <= cnt_n;
            len          <= len_n;
            bus.dec_valid <= valid_n;
            bus.dec_lit  <= lit_n;
            bus.dec_pos  <= pos_n;
            bus.dec_char <= char_n;
            finish       <= fin_n;
            err          <= err | (accept && bus.tok_pos > 4'd6);
        end
    end
endmodule
